text_console: RTL

- Character-stream front end for the text-mode video path; sits directly upstream of the 40x32 character buffer that the scaled 8x8-font scanout reads.
- Accepts 7-bit ASCII over a valid/ready handshake and keeps a cursor.
- Interprets control codes and emits one buffer write per cycle (col, row, char) into the buffer's write port.
- Performs screen and line clears autonomously, back-pressuring the producer meanwhile.

---
 rtl/text_console_if.sv | 28 ++
 rtl/text_console.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/text_console_if.sv
// Producer handshake and character-buffer write port of the text console.
// The slave side is the console; the master side feeds characters and watches the writes.
interface text_console_if #(
   parameter int HCC    = 40,
   parameter int VCC    = 32,
   parameter int CHAR_W = 7
);
   localparam int COL_W = $clog2(HCC);
   localparam int ROW_W = $clog2(VCC);

   logic              in_valid;
   logic [CHAR_W-1:0] in_char;
   logic              in_ready;
   logic              wr_en;
   logic [COL_W-1:0]  wr_col;
   logic [ROW_W-1:0]  wr_row;
   logic [CHAR_W-1:0] wr_char;

   modport master (
      output in_valid, in_char,
      input  in_ready, wr_en, wr_col, wr_row, wr_char
   );

   modport slave (
      input  in_valid, in_char,
      output in_ready, wr_en, wr_col, wr_row, wr_char
   );
endinterface

// File: rtl/text_console.sv
// Character-stream front end: keeps a cursor, interprets control codes and
// issues one character-buffer write per cycle, including autonomous line/screen clears.
module text_console #(
   parameter int HCC    = 40,
   parameter int VCC    = 32,
   parameter int CHAR_W = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   text_console_if.slave          bus,
   output logic [$clog2(HCC)-1:0] cur_col,
   output logic [$clog2(VCC)-1:0] cur_row,
   output logic                   busy
);
   localparam int COL_W = $clog2(HCC);
   localparam int ROW_W = $clog2(VCC);

   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(HCC - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(VCC - 1);
   localparam logic [CHAR_W-1:0] C_SPACE  = CHAR_W'(32);
   localparam logic [CHAR_W-1:0] C_TILDE  = CHAR_W'(126);
   localparam logic [CHAR_W-1:0] C_BS     = CHAR_W'(8);
   localparam logic [CHAR_W-1:0] C_LF     = CHAR_W'(10);
   localparam logic [CHAR_W-1:0] C_FF     = CHAR_W'(12);
   localparam logic [CHAR_W-1:0] C_CR     = CHAR_W'(13);

   typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;

   state_t            state, state_nx;
   logic [COL_W-1:0]  col_nx, clr_col, clr_col_nx;
   logic [ROW_W-1:0]  row_nx, clr_row, clr_row_nx;
   logic              wr_en_p0, wr_en_nx;
   logic [COL_W-1:0]  wr_col_p0, wr_col_nx;
   logic [ROW_W-1:0]  wr_row_p0, wr_row_nx;
   logic [CHAR_W-1:0] wr_char_p0, wr_char_nx;

   // No scrolling: the bottom row wraps back to the top.
   function automatic logic [ROW_W-1:0] row_advance(input logic [ROW_W-1:0] r);
      return (r == LAST_ROW) ? '0 : r + ROW_W'(1);
   endfunction

   always_comb begin
      state_nx   = state;
      col_nx     = cur_col;
      row_nx     = cur_row;
      clr_col_nx = clr_col;
      clr_row_nx = clr_row;
      wr_en_nx   = 1'b0;
      wr_col_nx  = wr_col_p0;
      wr_row_nx  = wr_row_p0;
      wr_char_nx = wr_char_p0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_char >= C_SPACE && bus.in_char <= C_TILDE) begin
                  wr_en_nx   = 1'b1;
                  wr_col_nx  = cur_col;
                  wr_row_nx  = cur_row;
                  wr_char_nx = bus.in_char;
                  if (cur_col == LAST_COL) begin
                     col_nx   = '0;
                     row_nx   = row_advance(cur_row);
                     state_nx = CLR_LINE;
                  end else begin
                     col_nx = cur_col + COL_W'(1);
                  end
               end else begin
                  case (bus.in_char)
                     C_LF: begin
                        col_nx   = '0;
                        row_nx   = row_advance(cur_row);
                        state_nx = CLR_LINE;
                     end
                     C_CR: col_nx = '0;
                     C_BS: begin
                        if (cur_col != '0) begin
                           col_nx     = cur_col - COL_W'(1);
                           wr_en_nx   = 1'b1;
                           wr_col_nx  = cur_col - COL_W'(1);
                           wr_row_nx  = cur_row;
                           wr_char_nx = C_SPACE;
                        end
                     end
                     C_FF: begin
                        col_nx   = '0;
                        row_nx   = '0;
                        state_nx = CLR_SCREEN;
                     end
                     default: ;
                  endcase
               end
            end
         end
         // Clear counters always return to zero when a clear finishes.
         CLR_LINE: begin
            wr_en_nx   = 1'b1;
            wr_col_nx  = clr_col;
            wr_row_nx  = cur_row;
            wr_char_nx = C_SPACE;
            if (clr_col == LAST_COL) begin
               clr_col_nx = '0;
               state_nx   = IDLE;
            end else begin
               clr_col_nx = clr_col + COL_W'(1);
            end
         end
         CLR_SCREEN: begin
            wr_en_nx   = 1'b1;
            wr_col_nx  = clr_col;
            wr_row_nx  = clr_row;
            wr_char_nx = C_SPACE;
            if (clr_col == LAST_COL) begin
               clr_col_nx = '0;
               if (clr_row == LAST_ROW) begin
                  clr_row_nx = '0;
                  state_nx   = IDLE;
               end else begin
                  clr_row_nx = clr_row + ROW_W'(1);
               end
            end else begin
               clr_col_nx = clr_col + COL_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // p0: registered writes and cursor, one cycle after the accepting edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLR_SCREEN;
         cur_col    <= '0;
         cur_row    <= '0;
         clr_col    <= '0;
         clr_row    <= '0;
         wr_en_p0   <= 1'b0;
         wr_col_p0  <= '0;
         wr_row_p0  <= '0;
         wr_char_p0 <= '0;
      end else begin
         state      <= state_nx;
         cur_col    <= col_nx;
         cur_row    <= row_nx;
         clr_col    <= clr_col_nx;
         clr_row    <= clr_row_nx;
         wr_en_p0   <= wr_en_nx;
         wr_col_p0  <= wr_col_nx;
         wr_row_p0  <= wr_row_nx;
         wr_char_p0 <= wr_char_nx;
      end
   end

   assign bus.in_ready = (state == IDLE);
   assign busy         = (state != IDLE);
   assign bus.wr_en    = wr_en_p0;
   assign bus.wr_col   = wr_col_p0;
   assign bus.wr_row   = wr_row_p0;
   assign bus.wr_char  = wr_char_p0;
endmodule
